// File: rtl/alu_pkg.sv
// Shared definitions for the execute stage: ALU operation codes, mul/div FSM
// states and datapath width. The ID-stage decoder imports the same package.
package alu_pkg;

    localparam int WIDTH = 32;

    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_SUB   = 5'd1;
    localparam logic [4:0] OP_AND   = 5'd2;
    localparam logic [4:0] OP_OR    = 5'd3;
    localparam logic [4:0] OP_XOR   = 5'd4;
    localparam logic [4:0] OP_NOR   = 5'd5;
    localparam logic [4:0] OP_SLT   = 5'd6;
    localparam logic [4:0] OP_SLTU  = 5'd7;
    localparam logic [4:0] OP_SLL   = 5'd8;
    localparam logic [4:0] OP_SRL   = 5'd9;
    localparam logic [4:0] OP_SRA   = 5'd10;
    localparam logic [4:0] OP_LUI   = 5'd11;
    localparam logic [4:0] OP_MULT  = 5'd12;
    localparam logic [4:0] OP_MULTU = 5'd13;
    localparam logic [4:0] OP_DIV   = 5'd14;
    localparam logic [4:0] OP_DIVU  = 5'd15;
    localparam logic [4:0] OP_MFHI  = 5'd16;
    localparam logic [4:0] OP_MFLO  = 5'd17;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

    function automatic logic is_muldiv(input logic [4:0] op);
        return (op >= OP_MULT) && (op <= OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative 32-step multiply (shift-add) / divide (restoring) unit with HI/LO.
// op[1] selects divide, op[0] selects unsigned; signed ops work on magnitudes.
module muldiv_unit
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    md_state_t   state_r;
    md_state_t   state_next_s;
    logic [5:0]  count_r;
    logic [63:0] acc_r;
    logic [31:0] mcand_r;
    logic [31:0] dividend_r;
    logic        is_div_r;
    logic        neg_res_r;
    logic        neg_rem_r;
    logic        div_zero_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;

    logic        signed_op_s;
    logic [31:0] a_mag_s;
    logic [31:0] b_mag_s;
    logic [32:0] sum_s;
    logic [32:0] diff_s;
    logic [63:0] step_s;
    logic [63:0] prod_s;
    logic [31:0] quot_s;
    logic [31:0] rem_s;
    logic [31:0] hi_fix_s;
    logic [31:0] lo_fix_s;

    assign signed_op_s = ~op[0];
    assign a_mag_s     = (signed_op_s && a[31]) ? (32'd0 - a) : a;
    assign b_mag_s     = (signed_op_s && b[31]) ? (32'd0 - b) : b;
    assign busy        = (state_r == MD_BUSY);
    assign done        = (state_r == MD_DONE);
    assign hi          = hi_r;
    assign lo          = lo_r;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= MD_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; abort returns to IDLE from any state
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            MD_IDLE: begin
                if (start && !abort) begin
                    state_next_s = MD_BUSY;
                end else begin
                    state_next_s = MD_IDLE;
                end
            end
            MD_BUSY: begin
                if (abort) begin
                    state_next_s = MD_IDLE;
                end else if (count_r == 6'd31) begin
                    state_next_s = MD_DONE;
                end else begin
                    state_next_s = MD_BUSY;
                end
            end
            MD_DONE: state_next_s = MD_IDLE;
            default: state_next_s = MD_IDLE;
        endcase
    end

    // One iteration: multiply adds the multiplicand into the upper half and
    // shifts right; divide shifts left and trial-subtracts using a 33-bit window.
    always_comb begin
        sum_s  = {1'b0, acc_r[63:32]} + (acc_r[0] ? {1'b0, mcand_r} : 33'd0);
        diff_s = acc_r[63:31] - {1'b0, mcand_r};
        step_s = 64'd0;
        if (is_div_r) begin
            if (!diff_s[32]) begin
                step_s = {diff_s[31:0], acc_r[30:0], 1'b1};
            end else begin
                step_s = {acc_r[62:0], 1'b0};
            end
        end else begin
            step_s = {sum_s, acc_r[31:1]};
        end
    end

    // Sign fix-up and divide-by-zero override of the final iteration
    always_comb begin
        prod_s   = neg_res_r ? (64'd0 - step_s) : step_s;
        quot_s   = neg_res_r ? (32'd0 - step_s[31:0]) : step_s[31:0];
        rem_s    = neg_rem_r ? (32'd0 - step_s[63:32]) : step_s[63:32];
        hi_fix_s = prod_s[63:32];
        lo_fix_s = prod_s[31:0];
        if (is_div_r) begin
            if (div_zero_r) begin
                hi_fix_s = dividend_r;
                lo_fix_s = 32'hFFFF_FFFF;
            end else begin
                hi_fix_s = rem_s;
                lo_fix_s = quot_s;
            end
        end else begin
            hi_fix_s = prod_s[63:32];
            lo_fix_s = prod_s[31:0];
        end
    end

    // Operand latch, iteration registers and HI/LO update
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r    <= 6'd0;
            acc_r      <= 64'd0;
            mcand_r    <= 32'd0;
            dividend_r <= 32'd0;
            is_div_r   <= 1'b0;
            neg_res_r  <= 1'b0;
            neg_rem_r  <= 1'b0;
            div_zero_r <= 1'b0;
            hi_r       <= 32'd0;
            lo_r       <= 32'd0;
        end else begin
            case (state_r)
                MD_IDLE: begin
                    if (start && !abort) begin
                        count_r    <= 6'd0;
                        acc_r      <= {32'd0, a_mag_s};
                        mcand_r    <= b_mag_s;
                        dividend_r <= a;
                        is_div_r   <= op[1];
                        neg_res_r  <= signed_op_s & (a[31] ^ b[31]);
                        neg_rem_r  <= signed_op_s & a[31];
                        div_zero_r <= (b == 32'd0);
                    end
                end
                MD_BUSY: begin
                    if (!abort) begin
                        acc_r   <= step_s;
                        count_r <= count_r + 6'd1;
                        if (count_r == 6'd31) begin
                            hi_r <= hi_fix_s;
                            lo_r <= lo_fix_s;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: single-cycle ALU, operand/destination muxes, stall
// generation for the iterative mul/div unit and the EX/MEM stage register.
module ex_stage
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_in,
    input  logic        RegDst_in,
    input  logic        ALUSrc_in,
    input  logic [4:0]  ALUOp_in,
    input  logic        Branch_in,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic        RegWrite_in,
    input  logic [31:0] Reg1_in,
    input  logic [31:0] Reg2_in,
    input  logic [31:0] Ext_in,
    input  logic [4:0]  Rt_in,
    input  logic [4:0]  Rd_in,
    input  logic [4:0]  shamt_in,
    output logic        stall_out,
    output logic        Branch_out,
    output logic        MemRead_out,
    output logic        MemWrite_out,
    output logic        RegWrite_out,
    output logic        Zero_out,
    output logic [31:0] ALUResult_out,
    output logic [31:0] WriteData_out,
    output logic [4:0]  WriteReg_out
);

    logic [WIDTH-1:0] b_s;
    logic [WIDTH-1:0] alu_result_s;
    logic [WIDTH-1:0] hi_s;
    logic [WIDTH-1:0] lo_s;
    logic [4:0]       write_reg_s;
    logic             is_md_s;
    logic             md_busy_s;
    logic             md_done_s;
    logic             idle_s;
    logic             start_s;
    logic             stall_s;

    assign b_s         = ALUSrc_in ? Ext_in : Reg2_in;
    assign write_reg_s = RegDst_in ? Rd_in : Rt_in;
    assign is_md_s     = is_muldiv(ALUOp_in);
    assign idle_s      = !md_busy_s && !md_done_s;
    assign start_s     = idle_s && is_md_s && !flush_in;
    // A flush kills the in-flight mul/div, so it also releases the stall at once.
    assign stall_s     = !flush_in && ((idle_s && is_md_s) || md_busy_s);
    assign stall_out   = stall_s;

    muldiv_unit u_muldiv (
        .clk   (clk),
        .rst   (rst),
        .start (start_s),
        .abort (flush_in),
        .op    (ALUOp_in[1:0]),
        .a     (Reg1_in),
        .b     (Reg2_in),
        .busy  (md_busy_s),
        .done  (md_done_s),
        .hi    (hi_s),
        .lo    (lo_s)
    );

    // Single-cycle ALU; mul/div and unused codes produce 0
    always_comb begin
        alu_result_s = 32'd0;
        case (ALUOp_in)
            OP_ADD:  alu_result_s = Reg1_in + b_s;
            OP_SUB:  alu_result_s = Reg1_in - b_s;
            OP_AND:  alu_result_s = Reg1_in & b_s;
            OP_OR:   alu_result_s = Reg1_in | b_s;
            OP_XOR:  alu_result_s = Reg1_in ^ b_s;
            OP_NOR:  alu_result_s = ~(Reg1_in | b_s);
            OP_SLT:  alu_result_s = {31'd0, ($signed(Reg1_in) < $signed(b_s))};
            OP_SLTU: alu_result_s = {31'd0, (Reg1_in < b_s)};
            OP_SLL:  alu_result_s = b_s << shamt_in;
            OP_SRL:  alu_result_s = b_s >> shamt_in;
            OP_SRA:  alu_result_s = $signed(b_s) >>> shamt_in;
            OP_LUI:  alu_result_s = {b_s[15:0], 16'h0000};
            OP_MFHI: alu_result_s = hi_s;
            OP_MFLO: alu_result_s = lo_s;
            default: alu_result_s = 32'd0;
        endcase
    end

    // EX/MEM register: bubble on reset, flush or stall; a retiring mul/div
    // writes nothing to memory or the register file
    always_ff @(posedge clk) begin
        if (rst || flush_in || stall_s) begin
            Branch_out    <= 1'b0;
            MemRead_out   <= 1'b0;
            MemWrite_out  <= 1'b0;
            RegWrite_out  <= 1'b0;
            Zero_out      <= 1'b0;
            ALUResult_out <= 32'd0;
            WriteData_out <= 32'd0;
            WriteReg_out  <= 5'd0;
        end else begin
            Branch_out    <= Branch_in;
            MemRead_out   <= MemRead_in && !is_md_s;
            MemWrite_out  <= MemWrite_in && !is_md_s;
            RegWrite_out  <= RegWrite_in && !is_md_s;
            Zero_out      <= (alu_result_s == 32'd0);
            ALUResult_out <= alu_result_s;
            WriteData_out <= Reg2_in;
            WriteReg_out  <= write_reg_s;
        end
    end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage MIPS pipeline. Consumes the ID/EX stage-register outputs, computes single-cycle ALU results, runs MULT/MULTU/DIV/DIVU on an iterative 32-step unit with HI/LO registers, and drives the EX/MEM stage register. It stalls the upstream stages while a multiply or divide is in flight.

## Interface
- No parameters; data width fixed at 32, register index at 5.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `flush_in` in 1: kill the instruction in EX (branch taken in MEM).
- `RegDst_in`, `ALUSrc_in` in 1 each: EX control from ID/EX.
- `ALUOp_in` in 5: operation code.
- `Branch_in`, `MemRead_in`, `MemWrite_in`, `RegWrite_in` in 1 each: MEM/WB control.
- `Reg1_in`, `Reg2_in`, `Ext_in` in 32 each: operands, already forwarded upstream.
- `Rt_in`, `Rd_in`, `shamt_in` in 5 each.
- `stall_out` out 1: hold PC, IF/ID and ID/EX this cycle (combinational).
- `Branch_out`, `MemRead_out`, `MemWrite_out`, `RegWrite_out` out 1 each: registered EX/MEM control.
- `Zero_out` out 1: registered, ALU result == 0.
- `ALUResult_out`, `WriteData_out` out 32 each: registered result and store data (Reg2).
- `WriteReg_out` out 5: registered, `Rd` if `RegDst` else `Rt`.

## Operation
- B operand = `ALUSrc_in ? Ext_in : Reg2_in`.
- ALUOp codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT (signed), 7 SLTU, 8 SLL, 9 SRL, 10 SRA, 11 LUI, 12 MULT, 13 MULTU, 14 DIV, 15 DIVU, 16 MFHI, 17 MFLO. Codes 18–31 give result 0.
- ADD/SUB wrap modulo 2^32 with no overflow trap. Shifts shift B by `shamt_in`. LUI = {B[15:0],16'h0}. SLT/SLTU produce 0 or 1.
- MFHI/MFLO return the current HI/LO registers.
- Mul/div FSM has three states:
  - IDLE → BUSY when `ALUOp_in` is 12–15 and `flush_in`=0. Latch operands and load count=0.
  - BUSY stays for 32 cycles (count 0..31), one shift-add or restoring-subtract step per cycle. After step 31 it goes to DONE and writes HI/LO in the same edge.
  - DONE → IDLE unconditionally.
- Multiply results: HI:LO = 64-bit product. MULT is signed, MULTU unsigned.
- Divide results: LO = quotient, HI = remainder.
  - Signed divide works on magnitudes. Quotient is negated if the operand signs differ; the remainder takes the dividend's sign.
  - Divide by zero gives LO=32'hFFFF_FFFF and HI=dividend, for both signed and unsigned.
- `stall_out` = (IDLE & op∈12–15 & !flush_in) | BUSY.
- EX/MEM update every cycle:
  - If `flush_in` or `stall_out`: load a bubble, i.e. all four control bits 0 and data don't-care (the implementation drives 0).
  - Else: load the computed fields.
  - A mul/div op retires from DONE with RegWrite, MemRead and MemWrite forced 0.
- Flush during BUSY or DONE: next state IDLE, HI/LO unchanged, `stall_out` drops in the same cycle.
- `rst` clears all of the following on the next edge, and takes priority over `flush_in` and everything else:
  - FSM → IDLE, count 0.
  - HI=LO=0.
  - All EX/MEM outputs 0.

## Timing
- ALU ops: one-cycle latency from ID/EX outputs to EX/MEM outputs.
- Mul/div occupies EX for 34 cycles: issue cycle, 32 BUSY cycles, then DONE.
  - `stall_out` is high for 33 consecutive cycles (issue + BUSY).
  - EX/MEM receives 33 bubbles, then the retiring instruction.
- HI/LO are valid from DONE onward, so a MFHI/MFLO directly behind the mul/div reads the new value in its first EX cycle.
- A back-to-back mul/div re-issues only after DONE → IDLE, so it has no overlap with the previous one.
- `stall_out` is combinational from `ALUOp_in`, `flush_in` and state. There is no combinational path from `stall_out` back to any input.

## Structure
- Package `alu_pkg` holds the ALUOp localparams (0–17), the FSM state encoding (IDLE/BUSY/DONE) and `WIDTH=32`. The decoder in the ID stage shares this package.
- Sub-module `muldiv_unit` contains the FSM, 6-bit counter, operand/partial registers, sign fix-up and HI/LO. It exposes `start`, `op[1:0]`, `abort`, `busy`, `hi` and `lo`.
- The top level holds the combinational ALU, operand mux, WriteReg mux, stall logic and the EX/MEM register.

## Test plan
- ADD 0x7FFF_FFFF+1, SLT -1<1, SRA 0x8000_0000>>4 → ALUResult 0x8000_0000, 1, 0xF800_0000 one cycle later. Zero_out=0 in all three.
- MULT −3×7 then MFLO, MFHI → stall high 33 cycles, 33 bubbles, then LO=0xFFFF_FFEB and HI=0xFFFF_FFFF.
- DIV −7/2 → LO=0xFFFF_FFFD, HI=0xFFFF_FFFF. DIVU 5/0 → LO=0xFFFF_FFFF, HI=5.
- Flush at BUSY cycle 10 → stall drops that cycle, HI/LO keep their prior values, bubble enters EX/MEM, FSM is in IDLE.
- `rst` at BUSY cycle 20 → next cycle: all outputs 0, HI=LO=0, stall 0.
- LW-style op (ALUSrc=1, MemRead=1, RegDst=0, Rt=9) → WriteReg_out=9, MemRead_out=1, ALUResult = base+offset.
